// File: rtl/stab_regulator.sv
// rtl/stab_regulator.sv - tilt-error to stepper command regulator with deadband, slew ramp and stop-before-reverse
// Optional watchdog enabled by defining STAB_WATCHDOG_EN.
module stab_regulator #(
    parameter int ERR_W      = 12,
    parameter int DEADBAND   = 16,
    parameter int RATE_SHIFT = 6,
    parameter int RAMP_DIV   = 50000,
    parameter int TIMEOUT    = 2500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_valid,
    input  logic [ERR_W-1:0] err_data,
    output logic             rot_en,
    output logic             rot_dir,
    output logic [2:0]       set_rate,
    output logic [1:0]       state,
    output logic             timeout
);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2
    } st_t;

    localparam int CW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [ERR_W-1:0] MAG_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0] DB      = ERR_W'(DEADBAND);
    localparam logic [ERR_W-1:0] RATE_MAX_W = ERR_W'(7);

    st_t              st;
    logic [ERR_W-1:0] err_q;
    logic             tgt_en;
    logic             tgt_dir;
    logic [2:0]       tgt_rate;
    logic             tgt_live;
    logic [CW-1:0]    ramp_cnt;
    logic             tick;

    logic [ERR_W-1:0] mag;
    logic [ERR_W-1:0] excess;
    logic             en_next;
    logic [2:0]       rate_next;

    // The most negative sample has no positive twin, so it saturates.
    always_comb begin
        mag = err_q;
        if (err_q[ERR_W-1]) begin
            mag = (err_q == ERR_MIN) ? MAG_MAX : -err_q;
        end
        en_next   = (mag > DB);
        excess    = (mag - DB) >> RATE_SHIFT;
        rate_next = 3'd0;
        if (en_next) begin
            rate_next = (excess > RATE_MAX_W) ? 3'd7 : excess[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= '0;
            tgt_en   <= 1'b0;
            tgt_dir  <= 1'b0;
            tgt_rate <= 3'd0;
        end else begin
            if (err_valid) begin
                err_q <= err_data;
            end
            tgt_en   <= en_next;
            tgt_dir  <= ~err_q[ERR_W-1];
            tgt_rate <= rate_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp_cnt <= '0;
        end else if (tick) begin
            ramp_cnt <= '0;
        end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
        end
    end

    assign tick = (ramp_cnt == CW'(RAMP_DIV - 1));

`ifdef STAB_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;
    logic          wd_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else if (err_valid) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else if (!wd_flag) begin
            if (wd_cnt == TW'(TIMEOUT - 1)) begin
                wd_flag <= 1'b1;
            end
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout  = wd_flag;
    assign tgt_live = tgt_en & ~wd_flag;
`else
    // Constant 0; the comparison only keeps TIMEOUT referenced in this build.
    assign timeout  = (TIMEOUT < 0);
    assign tgt_live = tgt_en;
`endif

    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
        if (cur < tgt) begin
            return cur + 3'd1;
        end else if (cur > tgt) begin
            return cur - 3'd1;
        end
        return cur;
    endfunction

    // Direction is only ever loaded on the STOP -> RUN edge, so reversal always passes through zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= STOP;
            rot_en   <= 1'b0;
            rot_dir  <= 1'b0;
            set_rate <= 3'd0;
        end else if (tick) begin
            case (st)
                STOP: begin
                    if (tgt_live) begin
                        st       <= RUN;
                        rot_en   <= 1'b1;
                        rot_dir  <= tgt_dir;
                        set_rate <= 3'd0;
                    end
                end
                RUN: begin
                    if (!tgt_live || (tgt_dir != rot_dir)) begin
                        if (set_rate == 3'd0) begin
                            st     <= STOP;
                            rot_en <= 1'b0;
                        end else begin
                            st       <= BRAKE;
                            set_rate <= set_rate - 3'd1;
                        end
                    end else begin
                        set_rate <= step_toward(set_rate, tgt_rate);
                    end
                end
                BRAKE: begin
                    if (tgt_live && (tgt_dir == rot_dir)) begin
                        st       <= RUN;
                        set_rate <= step_toward(set_rate, tgt_rate);
                    end else if (set_rate != 3'd0) begin
                        set_rate <= set_rate - 3'd1;
                    end else begin
                        st     <= STOP;
                        rot_en <= 1'b0;
                    end
                end
                default: begin
                    st       <= STOP;
                    rot_en   <= 1'b0;
                    set_rate <= 3'd0;
                end
            endcase
        end
    end

    assign state = st;

endmodule
